// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one memory request in flight,
// buffers returned words in a small prefetch queue and handles redirects.
module fetch_unit #(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                        state;
  logic [PC_W-1:0]               fetch_pc;
  logic [PC_W-1:0]               drop_pc;
  logic [CNT_W-1:0]              count;
  logic [CNT_W-1:0]              count_next;
  logic [CNT_W-1:0]              enq_pos;
  logic [DEPTH-1:0]              q_vld;
  logic [DEPTH-1:0]              q_vld_next;
  logic [DEPTH-1:0][INSTR_W-1:0] q_instr;
  logic [DEPTH-1:0][INSTR_W-1:0] q_instr_next;
  logic [DEPTH-1:0][PC_W-1:0]    q_pc;
  logic [DEPTH-1:0][PC_W-1:0]    q_pc_next;
  logic                          enq;
  logic                          deq;
  logic                          can_issue;
  logic [PC_W-1:0]               addr_inc;

  // Entry 0 of the shift-style queue is the head, so the decode-facing outputs are flops.
  assign instr_valid = q_vld[0];
  assign instr       = q_instr[0];
  assign instr_pc    = q_pc[0];

  assign enq        = (state == WAIT) && mem_ack && !redirect;
  assign deq        = q_vld[0] && instr_ready;
  assign count_next = count + CNT_W'(enq) - CNT_W'(deq);
  assign enq_pos    = count - CNT_W'(deq);
  assign can_issue  = count_next < CNT_W'(DEPTH);
  assign addr_inc   = mem_addr + PC_W'(1);

  always_comb begin
    q_vld_next   = q_vld;
    q_instr_next = q_instr;
    q_pc_next    = q_pc;
    if (deq) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_vld_next[i]   = q_vld[i+1];
        q_instr_next[i] = q_instr[i+1];
        q_pc_next[i]    = q_pc[i+1];
      end
      q_vld_next[DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && (enq_pos == CNT_W'(i))) begin
        q_vld_next[i]   = 1'b1;
        q_instr_next[i] = mem_rdata;
        q_pc_next[i]    = mem_addr;
      end
    end
    if (redirect) begin
      q_vld_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld   <= '0;
      q_instr <= '0;
      q_pc    <= '0;
      count   <= '0;
    end else begin
      q_vld   <= q_vld_next;
      q_instr <= q_instr_next;
      q_pc    <= q_pc_next;
      count   <= redirect ? '0 : count_next;
    end
  end

  // Issue only when an ack is guaranteed a free queue slot; a redirect always empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= '0;
      drop_pc  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            mem_req  <= 1'b1;
            mem_addr <= redirect_pc;
            state    <= WAIT;
          end else if (can_issue) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (mem_ack) begin
              mem_addr <= redirect_pc;
            end else begin
              drop_pc <= redirect_pc;
              state   <= DROP;
            end
          end else if (mem_ack) begin
            fetch_pc <= addr_inc;
            if (can_issue) begin
              mem_addr <= addr_inc;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DROP: begin
          // The stale request must complete before the target can be fetched.
          if (redirect) begin
            fetch_pc <= redirect_pc;
            drop_pc  <= redirect_pc;
          end
          if (mem_ack) begin
            mem_addr <= redirect ? redirect_pc : drop_pc;
            state    <= WAIT;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction memory with programmable
// ack delay, a decode-side monitor, and hand-computed expected sequences.
module tb_fetch_unit;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               redirect = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready = 1'b0;

  logic        respAck = 1'b0;
  logic [31:0] respData = '0;
  logic        forceAck = 1'b0;
  logic [31:0] forceData = '0;
  logic        memOn = 1'b1;
  int          ackDelay = 0;
  int          waitCnt = 0;

  int vectors = 0;
  int miscompares = 0;

  logic [PC_W-1:0]    gotPc[$];
  logic [INSTR_W-1:0] gotInstr[$];
  logic [PC_W-1:0]    ackAddr[$];
  int                 stableErr = 0;
  logic               prevPending = 1'b0;
  logic [PC_W-1:0]    prevAddr = '0;

  assign mem_ack   = respAck | forceAck;
  assign mem_rdata = forceAck ? forceData : respData;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [PC_W-1:0] a);
    return {16'hC0DE, 10'h000, a};
  endfunction

  // Memory acks once a request has been visible for ackDelay cycles.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !mem_req) begin
      respAck = 1'b0;
      waitCnt = 0;
    end else if (memOn && waitCnt >= ackDelay) begin
      respAck  = 1'b1;
      respData = memWord(mem_addr);
      waitCnt  = 0;
    end else begin
      respAck = 1'b0;
      waitCnt++;
    end
  end

  // Records accepted instructions, completed requests and request-stability breaks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && instr_ready) begin
        gotPc.push_back(instr_pc);
        gotInstr.push_back(instr);
      end
      if (mem_req && mem_ack) ackAddr.push_back(mem_addr);
      if (prevPending && (!mem_req || mem_addr != prevAddr)) stableErr++;
      prevPending = mem_req && !mem_ack;
      prevAddr    = mem_addr;
    end else begin
      prevPending = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pcAt(input int i);
    return (i < gotPc.size()) ? 32'(gotPc[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] instrAt(input int i);
    return (i < gotInstr.size()) ? gotInstr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ackAt(input int i);
    return (i < ackAddr.size()) ? 32'(ackAddr[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [PC_W-1:0] rpc);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic doReset(input int delay, input logic on);
    rst_n    = 1'b0;
    forceAck = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    ackDelay = delay;
    memOn    = on;
    gotPc.delete();
    gotInstr.delete();
    ackAddr.delete();
    stableErr = 0;
    tick();
    tick();
  endtask

  task automatic releaseReset(input logic rdy, input logic redir, input logic [PC_W-1:0] rpc);
    rst_n = 1'b1;
    applyStimulus(rdy, redir, rpc);
    tick();
    redirect = 1'b0;
  endtask

  task automatic waitDeliveries(input int n, input int budget, input string tag);
    int cyc = 0;
    while (gotPc.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    checkOutput(tag, (gotPc.size() >= n) ? 32'(n) : 32'(gotPc.size()), 32'(n));
  endtask

  task automatic checkSeq(input string tag, input int first, input logic [PC_W-1:0] pc0,
                          input int n);
    logic [PC_W-1:0] pc;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_pc"}, pcAt(first + i), 32'(pc));
      checkOutput({tag, "_instr"}, instrAt(first + i), memWord(pc));
      pc = pc + PC_W'(1);
    end
  endtask

  initial begin
    // Reset values, then a zero-stall stream from address 0.
    doReset(0, 1'b1);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_instr_pc", 32'(instr_pc), 32'd0);
    releaseReset(1'b1, 1'b0, '0);
    checkOutput("first_req", 32'(mem_req), 32'd1);
    checkOutput("first_addr", 32'(mem_addr), 32'd0);
    waitDeliveries(8, 40, "stream_count");
    checkSeq("stream", 0, 6'd0, 8);
    checkOutput("stream_stable", 32'(stableErr), 32'd0);

    // Backpressure: exactly two words fetched, then in-order drain.
    doReset(0, 1'b1);
    releaseReset(1'b0, 1'b0, '0);
    repeat (10) tick();
    checkOutput("bp_req_low", 32'(mem_req), 32'd0);
    checkOutput("bp_ack_count", 32'(ackAddr.size()), 32'd2);
    checkOutput("bp_ack0", ackAt(0), 32'd0);
    checkOutput("bp_ack1", ackAt(1), 32'd1);
    checkOutput("bp_valid", 32'(instr_valid), 32'd1);
    checkOutput("bp_hold_pc", 32'(instr_pc), 32'd0);
    checkOutput("bp_hold_instr", instr, memWord(6'd0));
    applyStimulus(1'b1, 1'b0, '0);
    waitDeliveries(3, 30, "bp_count");
    checkSeq("bp", 0, 6'd0, 3);

    // Redirect from IDLE to 5, then redirect to 20 while the request to 5 is pending.
    doReset(4, 1'b1);
    releaseReset(1'b1, 1'b1, 6'd5);
    checkOutput("rw_req", 32'(mem_req), 32'd1);
    checkOutput("rw_addr5", 32'(mem_addr), 32'd5);
    applyStimulus(1'b1, 1'b1, 6'd20);
    tick();
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("rw_drop_req", 32'(mem_req), 32'd1);
    checkOutput("rw_drop_addr", 32'(mem_addr), 32'd5);
    waitDeliveries(2, 40, "rw_count");
    checkSeq("rw", 0, 6'd20, 2);
    checkOutput("rw_ack0", ackAt(0), 32'd5);
    checkOutput("rw_ack1", ackAt(1), 32'd20);
    checkOutput("rw_stable", 32'(stableErr), 32'd0);

    // Redirect in the same cycle as an ack: the acked word (pc 1) is dropped.
    doReset(0, 1'b1);
    releaseReset(1'b0, 1'b0, '0);
    tick();
    checkOutput("ra_pre_valid", 32'(instr_valid), 32'd1);
    checkOutput("ra_pre_pc", 32'(instr_pc), 32'd0);
    checkOutput("ra_pre_addr", 32'(mem_addr), 32'd1);
    applyStimulus(1'b0, 1'b1, 6'd10);
    tick();
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("ra_flush_valid", 32'(instr_valid), 32'd0);
    checkOutput("ra_req", 32'(mem_req), 32'd1);
    checkOutput("ra_addr", 32'(mem_addr), 32'd10);
    waitDeliveries(2, 30, "ra_count");
    checkSeq("ra", 0, 6'd10, 2);

    // Redirect with a full queue (3,4) while decode takes the head in that cycle.
    doReset(0, 1'b1);
    releaseReset(1'b0, 1'b1, 6'd3);
    repeat (6) tick();
    checkOutput("rf_full_valid", 32'(instr_valid), 32'd1);
    checkOutput("rf_full_pc", 32'(instr_pc), 32'd3);
    checkOutput("rf_full_instr", instr, memWord(6'd3));
    checkOutput("rf_full_req", 32'(mem_req), 32'd0);
    applyStimulus(1'b1, 1'b1, 6'd30);
    tick();
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("rf_flush_valid", 32'(instr_valid), 32'd0);
    checkOutput("rf_req", 32'(mem_req), 32'd1);
    checkOutput("rf_addr", 32'(mem_addr), 32'd30);
    waitDeliveries(3, 30, "rf_count");
    checkSeq("rf_head", 0, 6'd3, 1);
    checkSeq("rf", 1, 6'd30, 2);

    // PC wrap-around.
    doReset(0, 1'b1);
    releaseReset(1'b1, 1'b1, 6'd62);
    waitDeliveries(4, 30, "wrap_count");
    checkSeq("wrap", 0, 6'd62, 4);

    // Async reset mid-request, with a stray ack held across reset release.
    doReset(1, 1'b1);
    releaseReset(1'b0, 1'b1, 6'd9);
    tick();
    tick();
    checkOutput("ar_pre_valid", 32'(instr_valid), 32'd1);
    checkOutput("ar_pre_pc", 32'(instr_pc), 32'd9);
    checkOutput("ar_pre_addr", 32'(mem_addr), 32'd10);
    rst_n     = 1'b0;
    forceAck  = 1'b1;
    forceData = 32'hDEAD_BEEF;
    #1;
    checkOutput("ar_mem_req", 32'(mem_req), 32'd0);
    checkOutput("ar_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("ar_valid", 32'(instr_valid), 32'd0);
    checkOutput("ar_instr", instr, 32'd0);
    checkOutput("ar_instr_pc", 32'(instr_pc), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    forceAck = 1'b0;
    checkOutput("ar_post_req", 32'(mem_req), 32'd1);
    checkOutput("ar_post_addr", 32'(mem_addr), 32'd0);
    checkOutput("ar_late_ack_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, '0);
    waitDeliveries(1, 20, "ar_count");
    checkSeq("ar", 0, 6'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
